// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register
// and saturating stall/redirect performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic [31:0]      PCBranchD,
  input  logic [31:0]      RDF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] RedirectCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      r_pcf;
  logic [31:0]      r_instr_d;
  logic [31:0]      r_pcplus4_d;
  logic             r_valid_d;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_redir_cnt;

  logic [31:0] w_pcplus4_f;
  logic [31:0] w_jump_target;
  logic [31:0] w_pc_next;
  logic        w_jmp_v;
  logic        w_br_v;
  logic        w_flush;

  // A bubble in Decode must never steer the PC.
  assign w_jmp_v       = JumpD & r_valid_d;
  assign w_br_v        = PCSrcD & r_valid_d;
  assign w_flush       = (w_jmp_v | w_br_v) & ~StallD;
  assign w_pcplus4_f   = r_pcf + 32'd4;
  assign w_jump_target = {r_pcplus4_d[31:28], r_instr_d[25:0], 2'b00};

  always_comb begin
    w_pc_next = w_pcplus4_f;
    if (w_jmp_v) begin
      w_pc_next = w_jump_target;
    end else if (w_br_v) begin
      w_pc_next = {PCBranchD[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf       <= {RESET_PC[31:2], 2'b00};
      r_instr_d   <= 32'd0;
      r_pcplus4_d <= 32'd0;
      r_valid_d   <= 1'b0;
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (!StallF) begin
        r_pcf <= w_pc_next;
      end

      // Squash the wrong-path fetch; a stalled F with free D becomes a bubble
      // so the held PC's instruction does not enter Decode twice.
      if (w_flush || (!StallD && StallF)) begin
        r_instr_d   <= 32'd0;
        r_pcplus4_d <= 32'd0;
        r_valid_d   <= 1'b0;
      end else if (!StallD) begin
        r_instr_d   <= RDF;
        r_pcplus4_d <= w_pcplus4_f;
        r_valid_d   <= 1'b1;
      end

      if (StallF && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush && (r_redir_cnt != CNT_MAX)) begin
        r_redir_cnt <= r_redir_cnt + CNT_ONE;
      end
    end
  end

  assign PCF           = r_pcf;
  assign InstrD        = r_instr_d;
  assign PCPlus4D      = r_pcplus4_d;
  assign ValidD        = r_valid_d;
  assign StallCount    = r_stall_cnt;
  assign RedirectCount = r_redir_cnt;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes StallF/StallD from the hazard unit.
- Applies branch/jump redirects resolved in Decode.
- Drives the instruction-memory address and presents InstrD/PCPlus4D to Decode. Also keeps stall and redirect performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PC (from hazard unit)
- StallD  in  1  hold IF/ID register (from hazard unit)
- PCSrcD  in  1  branch taken, resolved in Decode
- JumpD  in  1  jump instruction in Decode
- PCBranchD  in  32  branch target computed in Decode
- RDF  in  32  instruction word read from imem at PCF (combinational memory)
- PCF  out  32  imem address / current fetch PC
- InstrD  out  32  instruction in Decode
- PCPlus4D  out  32  PC+4 of instruction in Decode
- ValidD  out  1  InstrD holds a real instruction (0 = bubble)
- StallCount  out  CNT_W  cycles with StallF=1
- RedirectCount  out  CNT_W  taken branch/jump redirects

Behaviour:
- Reset (reset=1 at a clk edge), overriding all other inputs:
  - PCF=RESET_PC.
  - InstrD=0, PCPlus4D=0, ValidD=0.
  - Both counters=0.
- PCPlus4F = PCF + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Redirect qualification: JmpV = JumpD & ValidD; BrV = PCSrcD & ValidD. A bubble never redirects.
- JumpTarget = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
- PCNext priority: JmpV -> JumpTarget; else BrV -> {PCBranchD[31:2], 2'b00}; else PCPlus4F.
- PC register:
  - StallF=0: PCF <= PCNext.
  - StallF=1: PCF holds.
  - A redirect under StallF=1 is not lost: the instruction stays in D (StallD=1) and the redirect is re-evaluated next cycle.
- IF/ID register, priority order:
  1. Redirect = (JmpV | BrV) & ~StallD: InstrD<=0, PCPlus4D<=0, ValidD<=0. The wrong-path instruction fetched at PCF is squashed.
  2. Else StallD=1: hold all three outputs.
  3. Else StallF=1 (StallD=0): insert a bubble (InstrD<=0, ValidD<=0, PCPlus4D<=0). Prevents the held PC's instruction entering D twice.
  4. Else: InstrD<=RDF, PCPlus4D<=PCPlus4F, ValidD<=1.
- Latency: an instruction at PCF in cycle n appears on InstrD in cycle n+1 if unstalled. Branch/jump penalty is exactly 1 bubble.
- StallCount: +1 on each edge with StallF=1 and reset=0; saturates at all-ones (no wrap).
- RedirectCount: +1 on each edge where the IF/ID flush (rule 1) fires; saturates at all-ones.
- JmpV and BrV both set: jump wins; RedirectCount increments once.
- Reset asserted mid-stall or mid-redirect: reset wins in that cycle. The first fetch after deassertion is at RESET_PC.
- PCF is registered only. InstrD, PCPlus4D and ValidD are registered only. No combinational path from RDF to any output.

Test Plan:
- Sequential fetch: reset with RESET_PC=0, release, no stalls, imem[i]=0x2000_0000+i.
  - PCF steps 0,4,8,C.
  - InstrD shows 0x2000_0000, 0x2000_0001… one cycle behind.
  - PCPlus4D shows 4, 8…; ValidD=1 from the 2nd cycle.
- Stall: StallF=StallD=1 for 3 cycles with PCF=0x10.
  - PCF, InstrD and PCPlus4D hold; StallCount=3.
  - On release, the 0x10 instruction enters D exactly once.
- Taken branch: InstrD at PC 0x08 valid, PCSrcD=1, PCBranchD=0x40.
  - Next cycle PCF=0x40, ValidD=0, RedirectCount=1.
  - The following cycle InstrD = imem[0x40].
- Jump plus branch simultaneously: InstrD=0x0800_0020, PCPlus4D=0x0000_0010, JumpD=1, PCSrcD=1, PCBranchD=0x80.
  - PCF=0x80 (jump target {0x0,0x20<<2}), jump wins.
  - RedirectCount +1 only.
- Redirect under stall, then bubble: PCSrcD=1, StallF=StallD=1 for 1 cycle.
  - No PC change and no flush during the stall.
  - Next cycle with stalls low: redirect taken.
  - Separately, StallF=1/StallD=0: ValidD=0 next cycle, InstrD=0.
- Wrap and reset: PCF=0xFFFF_FFFC gives next PCF=0.
  - Assert reset during StallF=1: PCF=RESET_PC, ValidD=0, both counters 0.
  - Counter preloaded near all-ones with CNT_W=4: StallCount saturates at 15.
